// File: rtl/cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug RAM arbiter.
package cpu_ocimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AV_WR,
        ST_AV_RD,
        ST_AV_RDW,
        ST_J_WR,
        ST_J_RD,
        ST_J_RDW
    } state_t;

    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_ADDR_LSB  = 2;
    localparam int JDO_WDATA_W   = JDO_WDATA_MSB - JDO_WDATA_LSB + 1;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/cpu_ocimem_jtag_cmd.sv
// JTAG strobe capture: pending write/read flags, write-data latch and sticky overrun.
module cpu_ocimem_jtag_cmd
    import cpu_ocimem_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_take_a,
    input  logic                   i_take_b,
    input  logic                   i_take_rd,
    input  logic [JDO_WDATA_W-1:0] i_wdata,
    input  logic                   i_clr_wr,
    input  logic                   i_clr_rd,
    output logic                   o_acc_a,
    output logic                   o_acc_b,
    output logic                   o_acc_rd,
    output logic                   o_pend_wr,
    output logic                   o_pend_rd,
    output logic [JDO_WDATA_W-1:0] o_wr_data,
    output logic                   o_overrun
);

    logic                   r_pend_wr;
    logic                   r_pend_rd;
    logic                   r_overrun;
    logic [JDO_WDATA_W-1:0] r_wr_data;
    logic                   w_busy;
    logic                   w_any;
    logic                   w_drop;

    assign w_busy = r_pend_wr | r_pend_rd;
    assign w_any  = i_take_a | i_take_b | i_take_rd;

    // At most one strobe is accepted per cycle, and none while a JTAG access is queued.
    assign o_acc_a  = i_take_a & ~w_busy;
    assign o_acc_b  = i_take_b & ~i_take_a & ~w_busy;
    assign o_acc_rd = i_take_rd & ~i_take_a & ~i_take_b & ~w_busy;

    assign w_drop = (w_busy & w_any) | (i_take_a & (i_take_b | i_take_rd)) | (i_take_b & i_take_rd);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pend_wr <= 1'b0;
            r_pend_rd <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_clr_wr)
                r_pend_wr <= 1'b0;
            else if (o_acc_b)
                r_pend_wr <= 1'b1;
            if (i_clr_rd)
                r_pend_rd <= 1'b0;
            else if (o_acc_rd)
                r_pend_rd <= 1'b1;
            if (w_drop)
                r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_acc_b)
            r_wr_data <= i_wdata;
    end

    assign o_pend_wr = r_pend_wr;
    assign o_pend_rd = r_pend_rd;
    assign o_wr_data = r_wr_data;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/cpu_ocimem_arbiter.sv
// Sysclk arbiter sharing the OCI debug RAM between Avalon and JTAG; owns MonAReg/MonDReg.
// Optional OCIMEM_ROM_PROTECT_EN: suppress Avalon writes to the lower half unless debugack.
module cpu_ocimem_arbiter
    import cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] av_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_waitreq;
    logic              w_clr_wr;
    logic              w_clr_rd;
    logic              w_jtag_done;
    logic              w_acc_a;
    logic              w_acc_b;
    logic              w_acc_rd;
    logic              w_pend_wr;
    logic              w_pend_rd;
    logic [31:0]       w_wr_data;
    logic              w_wr_block;
    logic              w_unused_jdo;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wren;
    logic [3:0]        r_ram_byteen;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [ADDR_W-1:0] r_mon_areg;
    logic [DATA_W-1:0] r_mon_dreg;
    logic              r_mon_ready;
    logic [DATA_W-1:0] r_av_rdata;

    assign w_unused_jdo = ^{jdo[37:35], jdo[1:0]};

`ifdef OCIMEM_ROM_PROTECT_EN
    assign w_wr_block = ~av_address[ADDR_W-1] & ~debugack;
`else
    logic w_unused_dbg;
    assign w_unused_dbg = debugack;
    assign w_wr_block   = 1'b0;
`endif

    cpu_ocimem_jtag_cmd u_jtag_cmd (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_take_a  (take_action_ocimem_a),
        .i_take_b  (take_action_ocimem_b),
        .i_take_rd (take_no_action_ocimem_a),
        .i_wdata   (jdo[JDO_WDATA_MSB:JDO_WDATA_LSB]),
        .i_clr_wr  (w_clr_wr),
        .i_clr_rd  (w_clr_rd),
        .o_acc_a   (w_acc_a),
        .o_acc_b   (w_acc_b),
        .o_acc_rd  (w_acc_rd),
        .o_pend_wr (w_pend_wr),
        .o_pend_rd (w_pend_rd),
        .o_wr_data (w_wr_data),
        .o_overrun (jtag_overrun)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // JTAG work only preempts at IDLE, so an in-flight Avalon access always finishes.
    always_comb begin
        w_state_nxt = r_state;
        w_waitreq   = 1'b1;
        w_clr_wr    = 1'b0;
        w_clr_rd    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pend_wr)      w_state_nxt = ST_J_WR;
                else if (w_pend_rd) w_state_nxt = ST_J_RD;
                else if (av_read)   w_state_nxt = ST_AV_RD;
                else if (av_write)  w_state_nxt = ST_AV_WR;
            end
            ST_AV_WR: begin
                w_waitreq   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            ST_AV_RD:  w_state_nxt = ST_AV_RDW;
            ST_AV_RDW: begin
                w_waitreq   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            ST_J_WR: begin
                w_clr_wr    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_J_RD:  w_state_nxt = ST_J_RDW;
            ST_J_RDW: begin
                w_clr_rd    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_jtag_done = w_clr_wr | w_clr_rd;

    // RAM port is registered: it is loaded on the IDLE exit so it is valid throughout the access state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ram_addr   <= '0;
            r_ram_wren   <= 1'b0;
            r_ram_byteen <= '0;
            r_ram_wdata  <= '0;
        end else begin
            r_ram_wren <= 1'b0;
            if (r_state == ST_IDLE) begin
                unique case (w_state_nxt)
                    ST_AV_WR: begin
                        r_ram_wren   <= ~w_wr_block;
                        r_ram_addr   <= av_address;
                        r_ram_byteen <= av_byteenable;
                        r_ram_wdata  <= av_writedata;
                    end
                    ST_AV_RD: r_ram_addr <= av_address;
                    ST_J_WR: begin
                        r_ram_wren   <= 1'b1;
                        r_ram_addr   <= r_mon_areg;
                        r_ram_byteen <= BE_ALL;
                        r_ram_wdata  <= w_wr_data;
                    end
                    ST_J_RD: r_ram_addr <= r_mon_areg;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mon_areg  <= '0;
            r_mon_dreg  <= '0;
            r_mon_ready <= 1'b0;
        end else begin
            if (w_acc_a)
                r_mon_areg <= jdo[JDO_ADDR_LSB +: ADDR_W];
            else if (w_jtag_done)
                r_mon_areg <= r_mon_areg + ADDR_W'(1);
            if (w_acc_a || w_jtag_done)
                r_mon_ready <= 1'b1;
            else if (w_acc_b || w_acc_rd)
                r_mon_ready <= 1'b0;
            if (w_clr_rd)
                r_mon_dreg <= ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_AV_RDW)
            r_av_rdata <= ram_rdata;
    end

    assign av_readdata    = (r_state == ST_AV_RDW) ? ram_rdata : r_av_rdata;
    assign av_waitrequest = w_waitreq;
    assign ram_addr       = r_ram_addr;
    assign ram_wren       = r_ram_wren;
    assign ram_byteen     = r_ram_byteen;
    assign ram_wdata      = r_ram_wdata;
    assign MonAReg        = r_mon_areg;
    assign MonDReg        = r_mon_dreg;
    assign monitor_ready  = r_mon_ready;

endmodule

// File: tb/tb_cpu_ocimem_arbiter.sv
// Scoreboard bench for cpu_ocimem_arbiter: expected RAM writes and Avalon reads are queued, a monitor pops them.
module tb_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta, tb_b, tn, debugack;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  MonAReg;
    logic [31:0] MonDReg;
    logic        monitor_ready, jtag_overrun;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta), .take_action_ocimem_b(tb_b),
        .take_no_action_ocimem_a(tn), .debugack(debugack),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .MonAReg(MonAReg), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun)
    );

    // Single-port RAM, 1-cycle read latency; known words are loaded while in reset.
    always @(posedge clk) begin
        if (!reset_n) begin
            mem[8'h11] <= 32'h12345678;
            mem[8'h20] <= 32'hA55A0020;
            mem[8'h21] <= 32'h11112222;
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every RAM write and every completed Avalon read must match the queue head.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (ram_wren === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr, ram_wdata);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(e.a));
                    chk("wr_data", ram_wdata, e.d);
                    chk("wr_be", 32'(ram_byteen), 32'(e.be));
                end
            end
            if (av_read === 1'b1 && av_waitrequest === 1'b0) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %h expected none", av_readdata);
                end else begin
                    chk("av_readdata", av_readdata, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jset_addr(input logic [7:0] a);
        jdo = 38'(a) << 2;
        ta = 1'b1;
        tick();
        ta = 1'b0;
    endtask

    task automatic jwrite(input logic [31:0] d);
        jdo = {3'b000, d, 3'b000};
        tb_b = 1'b1;
        tick();
        tb_b = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (monitor_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic av_xfer(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] be, output int n);
        av_address = a; av_read = rd; av_write = wr; av_writedata = d; av_byteenable = be;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (av_waitrequest !== 1'b0 && n < 20);
        chk("av_no_timeout", 32'(av_waitrequest), 32'h0);
        @(posedge clk);
        #1;
        av_read = 1'b0;
        av_write = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; jdo = '0; ta = 0; tb_b = 0; tn = 0; debugack = 0;
        av_address = '0; av_read = 0; av_write = 0; av_writedata = '0; av_byteenable = '0;
        tick(); tick();
        chk("rst_wren", 32'(ram_wren), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_monareg", 32'(MonAReg), 0);
        chk("rst_mondreg", MonDReg, 0);
        chk("rst_ready", 32'(monitor_ready), 0);
        chk("rst_overrun", 32'(jtag_overrun), 0);
        chk("rst_waitreq", 32'(av_waitrequest), 1);
        reset_n = 1'b1;
        tick();

        // JTAG address load then write
        jset_addr(8'h10);
        chk("seta_monareg", 32'(MonAReg), 32'h10);
        chk("seta_ready", 32'(monitor_ready), 1);
        wr_q.push_back({8'h10, 32'hDEADBEEF, 4'hF});
        jwrite(32'hDEADBEEF);
        chk("jwr_ready_low", 32'(monitor_ready), 0);
        wait_ready(n);
        chk("jwr_latency", 32'(n), 2);
        chk("jwr_monareg", 32'(MonAReg), 32'h11);

        // JTAG read of preloaded word
        tn = 1'b1;
        tick();
        tn = 1'b0;
        wait_ready(n);
        chk("jrd_latency", 32'(n), 3);
        chk("jrd_mondreg", MonDReg, 32'h12345678);
        chk("jrd_monareg", 32'(MonAReg), 32'h12);

        // Address wrap
        jset_addr(8'hFF);
        wr_q.push_back({8'hFF, 32'hCAFEF00D, 4'hF});
        jwrite(32'hCAFEF00D);
        wait_ready(n);
        chk("wrap_monareg", 32'(MonAReg), 32'h00);

        // Contention: JTAG write strobe during Avalon read, then a new Avalon read waits for J_WR
        av_address = 8'h20; av_read = 1'b1;
        rd_q.push_back(32'hA55A0020);
        tick();
        chk("cont_rd_wait", 32'(av_waitrequest), 1);
        wr_q.push_back({8'h00, 32'h0BADCAFE, 4'hF});
        jdo = {3'b000, 32'h0BADCAFE, 3'b000};
        tb_b = 1'b1;
        tick();
        tb_b = 1'b0;
        chk("cont_rdw_nowait", 32'(av_waitrequest), 0);
        tick();
        av_address = 8'h21;
        rd_q.push_back(32'h11112222);
        chk("cont_idle_wait", 32'(av_waitrequest), 1);
        tick();
        chk("cont_jwr_wren", 32'(ram_wren), 1);
        chk("cont_jwr_waitreq", 32'(av_waitrequest), 1);
        av_xfer(1'b1, 1'b0, 8'h21, 32'h0, 4'h0, n);
        chk("cont_monareg", 32'(MonAReg), 32'h01);

        // Overrun: second write strobe one cycle after the first is dropped
        chk("ovr_before", 32'(jtag_overrun), 0);
        wr_q.push_back({8'h01, 32'h55AA55AA, 4'hF});
        jdo = {3'b000, 32'h55AA55AA, 3'b000};
        tb_b = 1'b1;
        tick();
        jdo = {3'b000, 32'h99999999, 3'b000};
        tick();
        tb_b = 1'b0;
        chk("ovr_set", 32'(jtag_overrun), 1);
        wait_ready(n);
        chk("ovr_monareg", 32'(MonAReg), 32'h02);
        tick(); tick(); tick();
        chk("ovr_sticky", 32'(jtag_overrun), 1);

        // Reset while a JTAG write is pending: no write afterwards
        jdo = {3'b000, 32'h77777777, 3'b000};
        tb_b = 1'b1;
        tick();
        tb_b = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("midrst_wren", 32'(ram_wren), 0);
        chk("midrst_overrun", 32'(jtag_overrun), 0);
        chk("midrst_monareg", 32'(MonAReg), 0);
        reset_n = 1'b1;
        tick();
        chk("postrst_wren", 32'(ram_wren), 0);
        chk("postrst_waitreq", 32'(av_waitrequest), 1);

        // Coincident strobes: address load wins, write ignored
        jdo = 38'(8'h40) << 2;
        ta = 1'b1; tb_b = 1'b1;
        tick();
        ta = 1'b0; tb_b = 1'b0;
        chk("coin_monareg", 32'(MonAReg), 32'h40);
        chk("coin_overrun", 32'(jtag_overrun), 1);
        tick(); tick(); tick(); tick();
        chk("coin_ready", 32'(monitor_ready), 1);

        // Avalon writes: lower half with and without debugack, then upper half
        debugack = 1'b0;
`ifndef OCIMEM_ROM_PROTECT_EN
        wr_q.push_back({8'h05, 32'h00000505, 4'h3});
`endif
        av_xfer(1'b0, 1'b1, 8'h05, 32'h00000505, 4'h3, n);
        chk("avwr_latency", 32'(n), 2);
        debugack = 1'b1;
        wr_q.push_back({8'h05, 32'hAABBCCDD, 4'hF});
        av_xfer(1'b0, 1'b1, 8'h05, 32'hAABBCCDD, 4'hF, n);
        debugack = 1'b0;
        wr_q.push_back({8'h85, 32'h01020304, 4'hF});
        av_xfer(1'b0, 1'b1, 8'h85, 32'h01020304, 4'hF, n);

        // Read and write together: read wins, no RAM write
        rd_q.push_back(32'hAABBCCDD);
        av_xfer(1'b1, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, n);
        chk("avrd_latency", 32'(n), 3);
        tick();
        chk("avrd_hold", av_readdata, 32'hAABBCCDD);
        rd_q.push_back(32'h01020304);
        av_xfer(1'b1, 1'b0, 8'h85, 32'h0, 4'h0, n);

        tick(); tick(); tick();
        chk("wr_q_drained", 32'(wr_q.size()), 0);
        chk("rd_q_drained", 32'(rd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
